// File: rtl/red_beat_detector_pkg.sv
// Shared widths, detector state encoding and the rate-conversion constant.
// The optional BPM divider is enabled with the BEAT_RATE_EN macro.
package red_beat_detector_pkg;

    localparam int unsigned SAMPLE_W   = 20;
    localparam int unsigned PERIOD_W   = 11;
    localparam int unsigned QUOT_W     = 15;
    // 60 s/min x 500 samples/s
    localparam int unsigned FS_BPM_NUM = 30000;

    typedef enum logic [1:0] {
        StWarmup,
        StRise,
        StFall
    } det_state_t;

endpackage

// File: rtl/red_beat_detector_bpm_divider.sv
// Sequential restoring divider, one quotient bit per cycle; done pulses 16 cycles after start.
// Only instantiated when BEAT_RATE_EN is defined.
module red_beat_detector_bpm_divider
    import red_beat_detector_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [QUOT_W-1:0]   dividend,
    input  logic [PERIOD_W-1:0] divisor,
    output logic                done,
    output logic [QUOT_W-1:0]   quotient
);

    logic                busy;
    logic [3:0]          count;
    logic [PERIOD_W-1:0] rem;
    logic [QUOT_W-1:0]   work;
    logic [PERIOD_W:0]   trial;
    logic [PERIOD_W:0]   diff;
    logic                take;

    always_comb begin
        trial = {rem, work[QUOT_W-1]};
        diff  = trial - {1'b0, divisor};
        take  = (trial >= {1'b0, divisor});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            count    <= '0;
            rem      <= '0;
            work     <= '0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                count <= '0;
                rem   <= '0;
                work  <= dividend;
            end else if (busy) begin
                // remainder stays below divisor, so the top trial bit never survives
                rem   <= take ? diff[PERIOD_W-1:0] : trial[PERIOD_W-1:0];
                work  <= {work[QUOT_W-2:0], take};
                count <= count + 4'd1;
                if (count == 4'(QUOT_W - 1)) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= {work[QUOT_W-2:0], take};
                end
            end
        end
    end

endmodule

// File: rtl/red_beat_detector.sv
// Hysteresis peak/trough tracker measuring beat period and per-beat amplitude.
// Define BEAT_RATE_EN to add the sequential 30000/period BPM divider.
module red_beat_detector
    import red_beat_detector_pkg::*;
#(
    parameter int unsigned WARMUP     = 24,
    parameter int unsigned HYST       = 2048,
    parameter int unsigned MIN_PERIOD = 150,
    parameter int unsigned MAX_PERIOD = 1000
) (
    input  logic                CLK_Filter,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] In_RED_Filtered,
    output logic [SAMPLE_W-1:0] Peak_Value,
    output logic [SAMPLE_W-1:0] Trough_Value,
    output logic [SAMPLE_W-1:0] AC_Amplitude,
    output logic [PERIOD_W-1:0] Beat_Period,
    output logic                Beat_Valid,
    output logic                Beat_Lost,
    output logic [7:0]          Beat_BPM,
    output logic                BPM_Valid
);

    localparam int unsigned         WCNT_W = $clog2(WARMUP) + 1;
    localparam logic [SAMPLE_W:0]   HYST_W = (SAMPLE_W + 1)'(HYST);
    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P  = PERIOD_W'(MAX_PERIOD);

    det_state_t          state;
    logic [WCNT_W-1:0]   warm_cnt;
    logic [SAMPLE_W-1:0] cand_max;
    logic [SAMPLE_W-1:0] cand_min;
    logic [SAMPLE_W-1:0] trough_reg;
    logic [PERIOD_W-1:0] period_cnt;
    logic                has_prev;
    logic [SAMPLE_W:0]   drop_diff;
    logic [SAMPLE_W:0]   rise_diff;
    logic [SAMPLE_W:0]   ac_diff;
    logic                drop_ok;
    logic                rise_ok;
    logic                timeout;

    always_comb begin
        drop_diff = {1'b0, cand_max} - {1'b0, In_RED_Filtered};
        rise_diff = {1'b0, In_RED_Filtered} - {1'b0, cand_min};
        ac_diff   = {1'b0, cand_max} - {1'b0, trough_reg};
        // top bit is the borrow: a move in the wrong direction never confirms
        drop_ok   = !drop_diff[SAMPLE_W] && (drop_diff > HYST_W);
        rise_ok   = !rise_diff[SAMPLE_W] && (rise_diff > HYST_W);
        timeout   = has_prev && (period_cnt == MAX_P);
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StWarmup;
            warm_cnt     <= '0;
            cand_max     <= '0;
            cand_min     <= '0;
            trough_reg   <= '0;
            period_cnt   <= '0;
            has_prev     <= 1'b0;
            Peak_Value   <= '0;
            Trough_Value <= '0;
            AC_Amplitude <= '0;
            Beat_Period  <= '0;
            Beat_Valid   <= 1'b0;
            Beat_Lost    <= 1'b1;
        end else begin
            Beat_Valid <= 1'b0;
            if (timeout) begin
                Beat_Lost <= 1'b1;
                has_prev  <= 1'b0;
            end else if (has_prev) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end

            unique case (state)
                StWarmup: begin
                    warm_cnt <= warm_cnt + WCNT_W'(1);
                    if (warm_cnt == WCNT_W'(WARMUP - 1)) begin
                        state    <= StRise;
                        cand_max <= In_RED_Filtered;
                    end
                end
                StRise: begin
                    if (In_RED_Filtered > cand_max) cand_max <= In_RED_Filtered;
                    if (drop_ok) begin
                        state    <= StFall;
                        cand_min <= In_RED_Filtered;
                        // a timed-out peak restarts the measurement like a first peak
                        if (!has_prev || timeout) begin
                            has_prev   <= 1'b1;
                            period_cnt <= PERIOD_W'(1);
                        end else if (period_cnt >= MIN_P) begin
                            Beat_Valid   <= 1'b1;
                            Beat_Period  <= period_cnt;
                            Peak_Value   <= cand_max;
                            Trough_Value <= trough_reg;
                            AC_Amplitude <= ac_diff[SAMPLE_W] ? '0 : ac_diff[SAMPLE_W-1:0];
                            Beat_Lost    <= 1'b0;
                            period_cnt   <= PERIOD_W'(1);
                        end
                    end
                end
                StFall: begin
                    if (In_RED_Filtered < cand_min) cand_min <= In_RED_Filtered;
                    if (rise_ok) begin
                        trough_reg <= cand_min;
                        state      <= StRise;
                        cand_max   <= In_RED_Filtered;
                    end
                end
                default: state <= StWarmup;
            endcase
        end
    end

`ifdef BEAT_RATE_EN
    logic [QUOT_W-1:0] quot;
    logic              div_done;

    red_beat_detector_bpm_divider u_bpm_divider (
        .clk      (CLK_Filter),
        .rst_n    (rst_n),
        .start    (Beat_Valid),
        .dividend (QUOT_W'(FS_BPM_NUM)),
        .divisor  (Beat_Period),
        .done     (div_done),
        .quotient (quot)
    );

    assign Beat_BPM  = quot[7:0];
    assign BPM_Valid = div_done;
`else
    assign Beat_BPM  = '0;
    assign BPM_Valid = 1'b0;
`endif

endmodule

// File: tb/tb_red_beat_detector.sv
// Directed bench for red_beat_detector; BPM checks follow the BEAT_RATE_EN macro.
module tb_red_beat_detector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] din = 20'd1000;
    logic [19:0] peak, trough, ac;
    logic [10:0] period;
    logic        beat_valid, beat_lost, bpm_valid;
    logic [7:0]  bpm;

    int n_vec = 0, n_err = 0;
    int cyc = 0, last_bv = 0, n_pulse = 0, n_bpm = 0, first_t = -1;
    bit have_bv = 0;
    int exp_period = 250, exp_peak = 50000, exp_trough = 10000, exp_ac = 40000, exp_bpm = 120;

    red_beat_detector dut (
        .CLK_Filter      (clk),
        .rst_n           (rst_n),
        .In_RED_Filtered (din),
        .Peak_Value      (peak),
        .Trough_Value    (trough),
        .AC_Amplitude    (ac),
        .Beat_Period     (period),
        .Beat_Valid      (beat_valid),
        .Beat_Lost       (beat_lost),
        .Beat_BPM        (bpm),
        .BPM_Valid       (bpm_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_peak"}, 32'(peak), 0);
        check({tag, "_trough"}, 32'(trough), 0);
        check({tag, "_ac"}, 32'(ac), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_valid"}, 32'(beat_valid), 0);
        check({tag, "_lost"}, 32'(beat_lost), 1);
        check({tag, "_bpm"}, {23'd0, bpm_valid, bpm}, 0);
    endtask

    // One sample per clock; outputs sampled 1 time unit after the rising edge.
    task automatic step(input logic [19:0] v);
        @(negedge clk);
        din = v;
        @(posedge clk);
        #1;
        cyc++;
        if (beat_valid === 1'b1) begin
            n_pulse++;
            check("beat_period", 32'(period), exp_period);
            check("peak_value", 32'(peak), exp_peak);
            check("trough_value", 32'(trough), exp_trough);
            check("ac_amplitude", 32'(ac), exp_ac);
            check("lost_on_beat", 32'(beat_lost), 0);
            if (have_bv) check("beat_spacing", cyc - last_bv, exp_period);
            have_bv = 1;
            last_bv = cyc;
`ifndef BEAT_RATE_EN
            check("bpm_tied_off", {23'd0, bpm_valid, bpm}, 0);
`endif
        end
`ifdef BEAT_RATE_EN
        if (bpm_valid === 1'b1) begin
            n_bpm++;
            check("bpm_latency", cyc - last_bv, 16);
            check("bpm_value", 32'(bpm), exp_bpm);
        end
`endif
    endtask

    function automatic logic [19:0] tri_v(input int t);
        int m = t % 250;
        return (m <= 125) ? 20'(10000 + 320 * m) : 20'(10000 + 320 * (250 - m));
    endfunction

    // Main peak at 100, secondary peak at 200, period 300.
    function automatic logic [19:0] dh_v(input int t);
        int m = t % 300;
        if (m <= 100) return 20'(10000 + 400 * m);
        if (m <= 150) return 20'(50000 - 600 * (m - 100));
        if (m <= 200) return 20'(20000 + 400 * (m - 150));
        return 20'(40000 - 300 * (m - 200));
    endfunction

    initial begin
        // Reset and warmup on a flat input
        step(20'd1000);
        step(20'd1000);
        check_reset_vals("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(20'd1000);
        check("warmup_no_beat", n_pulse, 0);
        check_reset_vals("warmup");

        // Triangle lock, ending on a trough
        first_t = -1;
        for (int t = 0; t <= 1250; t++) begin
            step(tri_v(t));
            if (beat_valid === 1'b1 && first_t < 0) first_t = t;
        end
        check("tri_first_beat_t", first_t, 382);
        check("tri_beats", n_pulse, 4);
        check("tri_lost", 32'(beat_lost), 0);

        // Flat input until timeout
        for (int i = 0; i < 1100; i++) begin
            step(20'd10000);
            if (beat_lost === 1'b1) break;
        end
        check("timeout_lost", 32'(beat_lost), 1);
        check("timeout_delay", cyc - last_bv, 1000);
        check("timeout_no_beat", n_pulse, 4);

        // Restart: first peak silent, second reports a fresh period
        have_bv = 0;
        n_pulse = 0;
        first_t = -1;
        for (int t = 0; t < 400; t++) begin
            step(tri_v(t));
            if (beat_valid === 1'b1 && first_t < 0) first_t = t;
        end
        check("restart_first_beat_t", first_t, 382);
        check("restart_beats", n_pulse, 1);
        check("restart_lost", 32'(beat_lost), 0);

        // Asynchronous reset a few samples after a beat (divide in flight when enabled)
        for (int t = 400; t <= 637; t++) step(tri_v(t));
        check("pre_reset_beats", n_pulse, 2);
        check("pre_reset_peak", 32'(peak), 50000);
        n_bpm = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        step(20'd30000);
        step(20'd30000);
        rst_n = 1'b1;

        // Ripple below and exactly at the hysteresis never confirms
        n_pulse = 0;
        have_bv = 0;
        for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 20'd29000 : 20'd31000);
        for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 20'd28976 : 20'd31024);
        check("ripple_beats", n_pulse, 0);
        check("ripple_aborted_bpm", n_bpm, 0);
        check_reset_vals("ripple");

        // Double hump: secondary peaks inside the refractory window are rejected
        exp_period = 300;
        exp_bpm    = 100;
        first_t    = -1;
        for (int t = 50; t <= 1080; t++) begin
            step(dh_v(t));
            if (beat_valid === 1'b1 && first_t < 0) first_t = t;
        end
        check("dh_first_beat_t", first_t, 404);
        check("dh_beats", n_pulse, 3);
        check("dh_lost", 32'(beat_lost), 0);
`ifdef BEAT_RATE_EN
        check("dh_bpm_count", n_bpm, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
